// File: rtl/rc5_pkg.sv
// Shared RC5 (w=8) constants, FSM state type and size helpers for the key
// schedule and the encrypt/decrypt datapath.
package rc5_pkg;

  localparam int W = 32'sd8;
  localparam logic [7:0] P8 = 8'hB7;
  localparam logic [7:0] Q8 = 8'h9F;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MIX_A = 3'd2,
    MIX_B = 3'd3,
    DONE  = 3'd4
  } rc5_state_e;

  function automatic int rc5_t(input int rounds);
    return 32'sd2 * rounds + 32'sd2;
  endfunction

  function automatic int rc5_c(input int key_bytes);
    return (key_bytes < 32'sd1) ? 32'sd1 : key_bytes;
  endfunction

  function automatic int rc5_n(input int t, input int c);
    return 32'sd3 * ((t > c) ? t : c);
  endfunction

  // Index width that stays at least one bit for single-entry tables.
  function automatic int rc5_clog2(input int v);
    return (v <= 32'sd1) ? 32'sd1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rc5_key_schedule_if.sv
// Start/key request, status flags and S-table read port of the key schedule.
interface rc5_key_schedule_if
  import rc5_pkg::*;
#(
  parameter int ROUNDS    = 2,
  parameter int KEY_BYTES = 4
);
  localparam int T  = rc5_t(ROUNDS);
  localparam int AW = rc5_clog2(T);

  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
  logic                   busy;
  logic                   done;
  logic                   s_valid;
  logic [AW-1:0]          rd_addr;
  logic [7:0]             rd_data;

  modport master (output start, key, rd_addr, input busy, done, s_valid, rd_data);
  modport slave  (input start, key, rd_addr, output busy, done, s_valid, rd_data);

endinterface

// File: rtl/rc5_rotl8.sv
// 8-bit barrel rotate-left by a 3-bit amount; also used by the cipher datapath.
module rc5_rotl8 (
  input  logic [7:0] i_x,
  input  logic [2:0] i_n,
  output logic [7:0] o_y
);

  assign o_y = 8'(({i_x, i_x} << i_n) >> 4'd8);

endmodule

// File: rtl/rc5_key_schedule.sv
// RC5 w=8 key expansion: load L, magic-constant init of S, then 3*max(T,C)
// mixing steps split over MIX_A/MIX_B cycles; S is readable at all times.
module rc5_key_schedule
  import rc5_pkg::*;
#(
  parameter int ROUNDS    = 2,
  parameter int KEY_BYTES = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  rc5_key_schedule_if.slave if_bus
);

  localparam int T  = rc5_t(ROUNDS);
  localparam int C  = rc5_c(KEY_BYTES);
  localparam int N  = rc5_n(T, C);
  localparam int IW = rc5_clog2(T);
  localparam int JW = rc5_clog2(C);
  localparam int SW = rc5_clog2(N);
  localparam logic [IW-1:0] I_LAST    = IW'(T - 1);
  localparam logic [JW-1:0] J_LAST    = JW'(C - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);
  localparam logic [IW:0]   T_EXT     = (IW + 1)'(T);

  rc5_state_e    r_state;
  rc5_state_e    w_state_nx;
  logic [7:0]    r_s [0:T-1];
  logic [7:0]    r_l [0:C-1];
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [SW-1:0] r_step;
  logic          r_busy;
  logic          r_done;
  logic          r_s_valid;

  logic          w_accept;
  logic [7:0]    w_init;
  logic [7:0]    w_mix_a;
  logic [7:0]    w_mix_b;
  logic [2:0]    w_amt;

  assign w_accept = (r_state == IDLE) && if_bus.start;
  assign w_init   = (r_i == '0) ? P8 : (r_s[r_i - IW'(1)] + Q8);
  // MIX_B rotates by the A written in the preceding MIX_A cycle.
  assign w_amt    = 3'(r_a + r_b);

  rc5_rotl8 u_rotl_a (
    .i_x (r_s[r_i] + r_a + r_b),
    .i_n (3'd3),
    .o_y (w_mix_a)
  );

  rc5_rotl8 u_rotl_b (
    .i_x (r_l[r_j] + r_a + r_b),
    .i_n (w_amt),
    .o_y (w_mix_b)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (if_bus.start) w_state_nx = INIT; else w_state_nx = IDLE;
      INIT:    if (r_i == I_LAST) w_state_nx = MIX_A; else w_state_nx = INIT;
      MIX_A:   w_state_nx = MIX_B;
      MIX_B:   if (r_step == STEP_LAST) w_state_nx = DONE; else w_state_nx = MIX_A;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Status flags, registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      r_busy    <= (w_state_nx != IDLE);
      r_done    <= (w_state_nx == DONE);
      if (r_state == DONE) begin
        r_s_valid <= 1'b1;
      end else if (w_accept) begin
        r_s_valid <= 1'b0;
      end
    end
  end

  // Table, L words, A/B accumulators and the i/j/step counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < T; k++) r_s[k] <= 8'h00;
      for (int k = 0; k < C; k++) r_l[k] <= 8'h00;
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_i    <= '0;
      r_j    <= '0;
      r_step <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_bus.start) begin
            for (int k = 0; k < C; k++) r_l[k] <= if_bus.key[8*k +: 8];
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_i    <= '0;
            r_j    <= '0;
            r_step <= '0;
          end
        end
        INIT: begin
          r_s[r_i] <= w_init;
          r_i      <= (r_i == I_LAST) ? '0 : r_i + IW'(1);
        end
        MIX_A: begin
          r_s[r_i] <= w_mix_a;
          r_a      <= w_mix_a;
        end
        MIX_B: begin
          r_l[r_j] <= w_mix_b;
          r_b      <= w_mix_b;
          r_i      <= (r_i == I_LAST) ? '0 : r_i + IW'(1);
          r_j      <= (r_j == J_LAST) ? '0 : r_j + JW'(1);
          r_step   <= r_step + SW'(1);
        end
        DONE: begin
          r_step <= '0;
        end
        default: begin
          r_step <= '0;
        end
      endcase
    end
  end

  assign if_bus.busy    = r_busy;
  assign if_bus.done    = r_done;
  assign if_bus.s_valid = r_s_valid;
  assign if_bus.rd_data = ({1'b0, if_bus.rd_addr} < T_EXT) ? r_s[if_bus.rd_addr] : 8'h00;

endmodule
